vnu_ext_acc: RTL
================

Name: vnu_ext_acc

Overview:
- Variable-node accumulation stage of the shuffled VNU, directly downstream of the sign-magnitude to two's-complement converter.
- Takes one channel LLR and DEGREE check-to-variable (c2v) messages in two's complement, and forms the APP sum.
- Emits DEGREE extrinsic variable-to-check (v2c) messages, each equal to the sum minus its own c2v. Each message is saturated and converted back to sign-magnitude.
- Also outputs the hard decision.

Parameters:
- DATA_W, 6, width of c2v input and v2c output messages.
- LLR_W, 6, width of the channel LLR (two's complement).
- DEGREE, 4, messages per variable node (>=2).
- localparam SUM_W = max(DATA_W, LLR_W) + $clog2(DEGREE+1) + 1, internal accumulator width. The sum never overflows at this width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  pulse; starts a node and captures i_llr.
- i_llr  in  LLR_W  signed channel LLR.
- i_valid  in  1  c2v message valid.
- i_c2v  in  DATA_W  signed c2v message, from the converter.
- o_ready  out  1  stage accepts c2v this cycle.
- o_valid  out  1  v2c output valid.
- o_v2c  out  DATA_W  sign-magnitude extrinsic message.
- o_last  out  1  marks the DEGREE-th v2c.
- i_ready  in  1  downstream accepts v2c.
- o_app_hd  out  1  hard decision, 1 = negative APP.
- o_busy  out  1  node in progress (state != IDLE).

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; counters, buffer pointer and sum cleared.
  - o_ready, o_valid, o_last, o_app_hd, o_busy all 0; o_v2c = 0.
- Reset mid-operation aborts the node. No partial output follows.
- FSM states: IDLE, ACC, EMIT.
- IDLE:
  - o_ready=0.
  - i_start=1 → sum <= sext(i_llr), cnt <= 0, go to ACC.
  - i_valid is ignored in IDLE.
- ACC:
  - o_ready=1.
  - Beat = i_valid & o_ready.
  - Each beat: buffer[cnt] <= i_c2v, sum <= sum + sext(i_c2v), cnt++.
  - On the beat with cnt==DEGREE-1: go to EMIT, rd <= 0, o_app_hd <= (final sum < 0).
  - A zero sum gives o_app_hd = 0.
  - i_start is ignored in ACC and EMIT.
- EMIT:
  - o_ready=0.
  - Output register loads ext = sum - sext(buffer[rd]).
  - First o_valid is asserted the cycle after the last c2v beat.
  - o_v2c and o_last hold stable while o_valid & !i_ready.
  - Each transfer (o_valid & i_ready) advances rd and presents the next message the following cycle. The stage therefore sustains one message per cycle under constant i_ready.
  - o_last=1 with rd==DEGREE-1.
  - After the last transfer: o_valid <= 0, o_last <= 0, go to IDLE.
  - o_app_hd holds its value until the next node reaches EMIT.
- Saturation:
  - ext is clamped to the symmetric range ±(2^(DATA_W-1)-1), i.e. ±31 for DATA_W=6.
  - The most negative code never appears on o_v2c.
- SM conversion:
  - o_v2c = {ext<0, |ext|} after clamp.
  - Zero ext → all zeros (no negative zero).
- Input −2^(DATA_W-1), which the converter does not produce, is still accumulated arithmetically without error.
- Arithmetic is exact at SUM_W; there is no wrap-around anywhere.
- No overlap between nodes: the next i_start is accepted only once back in IDLE. o_busy lets the scheduler check this.

Test Plan:
- Basic: LLR=5, c2v 3, −2, 7, 1, i_ready=1.
  - sum=14; v2c 11, 16, 7, 13 → 0_01011, 0_10000, 0_00111, 0_01101.
  - o_last on the 4th; o_app_hd=0.
  - First o_valid exactly 1 cycle after the 4th c2v beat.
- Positive saturation: LLR=31, c2v 31, 31, 31, −31.
  - sum=93; v2c all clamp to +31 (0_11111), including 124 → 31.
  - o_app_hd=0.
- Negative saturation and zero: LLR=−20, c2v −10, −10, 0, 5.
  - sum=−35; v2c −25, −25, −31 (clamped from −35), −31 (from −40).
  - SM codes 1_11001, 1_11001, 1_11111, 1_11111; o_app_hd=1.
  - Variant LLR=0, c2v 2, −2, 0, 0: v2c −2, 2, 0, 0 → 1_00010, 0_00010, 0_00000, 0_00000; o_app_hd=0.
- Backpressure and throttling:
  - Random i_valid gaps during ACC do not change the results.
  - i_ready low 3 cycles on the 2nd output: o_v2c and o_last stay stable, and no message is dropped or duplicated.
  - Check the output count = DEGREE per node.
- Protocol:
  - i_start during ACC/EMIT is ignored (sum unchanged).
  - i_valid in IDLE is not consumed.
  - Back-to-back nodes give correct independent results.
- Reset mid-ACC (after 2 beats) and mid-EMIT:
  - All outputs go to 0 asynchronously; state returns to IDLE.
  - A following clean node produces correct values.

Source files
------------

// File: rtl/vnu_ext_acc.sv
// Variable-node accumulation stage: sums channel LLR with DEGREE c2v messages,
// then streams saturated sign-magnitude extrinsic v2c messages and a hard decision.
module vnu_ext_acc #(
    parameter int DATA_W = 6,
    parameter int LLR_W  = 6,
    parameter int DEGREE = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [LLR_W-1:0]  i_llr,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_c2v,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_v2c,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_app_hd,
    output logic              o_busy
);

    localparam int MAX_W = (DATA_W > LLR_W) ? DATA_W : LLR_W;
    localparam int SUM_W = MAX_W + $clog2(DEGREE + 1) + 1;
    localparam int CW    = $clog2(DEGREE);

    localparam logic [CW-1:0] LAST = CW'(DEGREE - 1);

    localparam logic signed [SUM_W-1:0] SAT_P = SUM_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_N = -SAT_P;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    logic [1:0]               state;
    logic [CW-1:0]            cnt;
    logic [CW-1:0]            rd;
    logic [CW-1:0]            rd_nxt;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_acc;
    logic signed [SUM_W-1:0]  ext_first;
    logic signed [SUM_W-1:0]  ext_next;
    logic [DATA_W-1:0]        buffer [DEGREE];
    logic                     beat;
    logic                     xfer;

    function automatic logic signed [SUM_W-1:0] sext_d(input logic [DATA_W-1:0] v);
        return {{(SUM_W - DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [SUM_W-1:0] sext_l(input logic [LLR_W-1:0] v);
        return {{(SUM_W - LLR_W){v[LLR_W-1]}}, v};
    endfunction

    // Symmetric clamp to +-(2^(DATA_W-1)-1), then sign-magnitude; zero stays positive.
    function automatic logic [DATA_W-1:0] to_sm(input logic signed [SUM_W-1:0] ext);
        logic                    neg;
        logic signed [SUM_W-1:0] mag;
        neg = ext[SUM_W-1];
        if (ext > SAT_P) begin
            mag = SAT_P;
        end else if (ext < SAT_N) begin
            mag = SAT_P;
        end else if (neg) begin
            mag = -ext;
        end else begin
            mag = ext;
        end
        return {neg, (DATA_W - 1)'(mag)};
    endfunction

    assign o_ready = (state == ACC);
    assign o_busy  = (state != IDLE);
    assign beat    = i_valid & o_ready;
    assign xfer    = o_valid & i_ready;

    // Next accumulator value and the extrinsic values for the first and next messages.
    always_comb begin
        rd_nxt    = rd + CW'(1);
        sum_acc   = sum + sext_d(i_c2v);
        ext_first = sum_acc - sext_d(buffer[0]);
        ext_next  = sum - sext_d(buffer[rd_nxt]);
    end

    // Node FSM: capture LLR, accumulate c2v beats, then stream extrinsic messages.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rd       <= '0;
            sum      <= '0;
            o_valid  <= 1'b0;
            o_v2c    <= '0;
            o_last   <= 1'b0;
            o_app_hd <= 1'b0;
            for (int i = 0; i < DEGREE; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        sum   <= sext_l(i_llr);
                        cnt   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        buffer[cnt] <= i_c2v;
                        sum         <= sum_acc;
                        if (cnt == LAST) begin
                            state    <= EMIT;
                            cnt      <= '0;
                            rd       <= '0;
                            o_app_hd <= sum_acc[SUM_W-1];
                            o_valid  <= 1'b1;
                            o_v2c    <= to_sm(ext_first);
                            o_last   <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        if (rd == LAST) begin
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            rd     <= rd_nxt;
                            o_v2c  <= to_sm(ext_next);
                            o_last <= (rd_nxt == LAST);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
